// File: rtl/clk_tick_pkg.sv
// ---------------------------------------------------------------------------
// clk_tick_pkg
// Shared definitions for the fractional clock-enable generator:
//   ACC_W        default accumulator / increment width
//   F_SYS_MHZ    system clock frequency the default increment is derived from
//   F_VGA_MHZ    VGA pixel strobe frequency the default increment targets
//   freq_to_inc  round(2^acc_w * f_out / f_sys), usable at elaboration time
//   DEFAULT_INC  reset increment (25.175 MHz strobe from a 50 MHz clock)
//   tick_ch_t    per-channel register layout at the default width
//   pend_state_t per-channel update state (idle / waiting for tick boundary)
// ---------------------------------------------------------------------------
package clk_tick_pkg;

  localparam int  ACC_W     = 32;
  localparam real F_SYS_MHZ = 50.0;
  localparam real F_VGA_MHZ = 25.175;

  // A real-to-integer cast rounds to nearest, which gives the
  // closest achievable average rate.
  function automatic longint freq_to_inc(real f_out_mhz, real f_sys_mhz, int acc_w);
    real scaled;
    scaled = (2.0 ** acc_w) * f_out_mhz / f_sys_mhz;
    return longint'(scaled);
  endfunction

  localparam longint DEFAULT_INC = freq_to_inc(F_VGA_MHZ, F_SYS_MHZ, ACC_W);

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] shadow;
    logic             pending;
  } tick_ch_t;

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_WAIT = 1'b1
  } pend_state_t;

endpackage

// File: rtl/clk_tick_gen_ch.sv
// ---------------------------------------------------------------------------
// clk_tick_ch
// One phase-accumulator tick channel with a shadowed increment. A retune
// written while the channel runs is held in the shadow register and only
// swapped in on the edge whose addition carries, so the tick in flight is
// never shortened or stretched.
// Optional feature macro: CLK_TICK_GEN_PHASE_SYNC_EN (adds the sync input).
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           run enable; when low the phase holds and no tick is issued
//   wr_en        accepted config write addressed to this channel
//   wr_inc       increment carried by that write
//   sync         phase-align pulse (only with CLK_TICK_GEN_PHASE_SYNC_EN)
//   tick         registered one-cycle tick
//   pending      a shadowed increment is waiting for its tick boundary
// ---------------------------------------------------------------------------
module clk_tick_ch
  import clk_tick_pkg::*;
#(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             pending
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             sync_hit;
  logic             apply_shadow;
  pend_state_t      state;
  pend_state_t      state_next;

`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // One extra bit so the wrap of the accumulator shows up as the carry.
  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_W];

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PEND_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A write only needs to wait when the channel is running and no sync is
  // applying everything at once; once waiting, any of carry, disable or sync
  // releases the shadow value.
  always_comb begin
    state_next = state;
    case (state)
      PEND_IDLE: if (wr_en && en && !sync_hit) state_next = PEND_WAIT;
      PEND_WAIT: if (sync_hit || !en || carry) state_next = PEND_IDLE;
      default:   state_next = PEND_IDLE;
    endcase
  end

  // Outputs of the pending machine.
  always_comb begin
    pending      = (state == PEND_WAIT);
    apply_shadow = (state == PEND_WAIT) && (sync_hit || !en || carry);
  end

  // Accumulator, increment and shadow datapath. The carrying addition still
  // uses the old increment; the swap lands on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      inc    <= RST_INC;
      shadow <= '0;
      tick   <= 1'b0;
    end else begin
      if (sync_hit) begin
        acc  <= '0;
        tick <= 1'b0;
      end else if (en) begin
        acc  <= sum[ACC_W-1:0];
        tick <= carry;
      end else begin
        tick <= 1'b0;
      end

      if (apply_shadow) begin
        inc <= shadow;
      end else if (wr_en && (!en || sync_hit)) begin
        inc <= wr_inc;
      end

      if (wr_en && en && !sync_hit) begin
        shadow <= wr_inc;
      end
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// ---------------------------------------------------------------------------
// clk_tick_gen
// Multi-channel fractional clock-enable generator. Each channel ticks at an
// average rate of f_sys * inc / 2^ACC_W. Increments are retuned through a
// valid/ready port and applied at the channel's next tick boundary.
// Optional feature macro: CLK_TICK_GEN_PHASE_SYNC_EN (adds sync_i, which
// zeroes every phase and applies all pending increments at once).
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   en_i          per-channel run enable
//   cfg_valid_i   config write request
//   cfg_ready_o   write to cfg_ch_i can be accepted (combinational)
//   cfg_ch_i      target channel; out-of-range writes are accepted and dropped
//   cfg_inc_i     new increment
//   sync_i        phase-align pulse (only with CLK_TICK_GEN_PHASE_SYNC_EN)
//   tick_o        registered one-cycle tick per channel
//   pending_o     per-channel update waiting for its tick boundary
// ---------------------------------------------------------------------------
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int     NUM_CH      = 4,
  parameter int     ACC_W       = clk_tick_pkg::ACC_W,
  parameter longint DEFAULT_INC = clk_tick_pkg::DEFAULT_INC,
  localparam int    CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [ACC_W-1:0]  cfg_inc_i,
`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
  input  logic              sync_i,
`endif
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pending_o
);

  localparam logic [ACC_W-1:0] RST_INC = DEFAULT_INC[ACC_W-1:0];

  logic              cfg_fire;
  logic [NUM_CH-1:0] wr_en;

  // Ready mux: a channel refuses new writes only while its previous retune
  // is still waiting. Addresses with no channel behind them are always ready
  // so the writer never stalls on them.
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch_i == CH_W'(c)) cfg_ready_o = !pending_o[c];
    end
  end

  assign cfg_fire = cfg_valid_i && cfg_ready_o;

  // Write decode; out-of-range channels match nothing and the write is lost.
  always_comb begin
    wr_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_en[c] = cfg_fire && (cfg_ch_i == CH_W'(c));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_tick_ch #(
      .ACC_W   (ACC_W),
      .RST_INC (RST_INC)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_i[c]),
      .wr_en   (wr_en[c]),
      .wr_inc  (cfg_inc_i),
`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
      .sync    (sync_i),
`endif
      .tick    (tick_o[c]),
      .pending (pending_o[c])
    );
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_gen
// Self-checking bench for clk_tick_gen with NUM_CH=2, ACC_W=8. A reference
// model tracks each channel's phase as an integer in [0,256) and decides
// ticks by plain overflow arithmetic. Exercises the phase-sync feature
// when CLK_TICK_GEN_PHASE_SYNC_EN is defined.
// ---------------------------------------------------------------------------
module tb_clk_tick_gen;

  localparam int MOD     = 256;
  // round(256 * 25.175 / 50) = round(128.896)
  localparam int DEF_INC = 129;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en_i = 2'b00;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic       cfg_ch_i = 1'b0;
  logic [7:0] cfg_inc_i = 8'd0;
  logic       sync_i = 1'b0;
  logic [1:0] tick_o;
  logic [1:0] pending_o;

  int errors = 0;
  int checks = 0;

  int         m_phase [2];
  int         m_inc   [2];
  int         m_shadow[2];
  logic [1:0] m_pend;
  logic [1:0] m_tick;

  always #5 clk = ~clk;

  clk_tick_gen #(
    .NUM_CH      (2),
    .ACC_W       (8),
    .DEFAULT_INC (DEF_INC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_inc_i   (cfg_inc_i),
`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
    .sync_i      (sync_i),
`endif
    .tick_o      (tick_o),
    .pending_o   (pending_o)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model --------------------------------------------------------
  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c]  = 0;
      m_inc[c]    = DEF_INC;
      m_shadow[c] = 0;
    end
    m_pend = 2'b00;
    m_tick = 2'b00;
  endtask

  function automatic logic m_ready();
    return !m_pend[cfg_ch_i];
  endfunction

  task automatic m_update();
    logic fire;
    logic wr;
    fire = cfg_valid_i && m_ready();
    for (int c = 0; c < 2; c++) begin
      wr = fire && (int'(cfg_ch_i) == c);
      if (sync_i) begin
        m_phase[c] = 0;
        m_tick[c]  = 1'b0;
        if (m_pend[c]) begin m_inc[c] = m_shadow[c]; m_pend[c] = 1'b0; end
        if (wr) m_inc[c] = int'(cfg_inc_i);
      end else if (!en_i[c]) begin
        m_tick[c] = 1'b0;
        if (m_pend[c]) begin m_inc[c] = m_shadow[c]; m_pend[c] = 1'b0; end
        if (wr) m_inc[c] = int'(cfg_inc_i);
      end else begin
        m_phase[c] = m_phase[c] + m_inc[c];
        m_tick[c]  = (m_phase[c] >= MOD);
        if (m_tick[c]) m_phase[c] = m_phase[c] - MOD;
        if (m_pend[c] && m_tick[c]) begin m_inc[c] = m_shadow[c]; m_pend[c] = 1'b0; end
        if (wr) begin m_shadow[c] = int'(cfg_inc_i); m_pend[c] = 1'b1; end
      end
    end
  endtask

  // Stimulus helpers -------------------------------------------------------
  task automatic step();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic drive_write(input logic ch, input logic [7:0] v);
    cfg_valid_i = 1'b1;
    cfg_ch_i    = ch;
    cfg_inc_i   = v;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    en_i        = 2'b00;
    cfg_valid_i = 1'b0;
    sync_i      = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Tests ------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    #3;
    checks++;
    if (tick_o !== 2'b00 || pending_o !== 2'b00 || cfg_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: tick=%b pend=%b ready=%b, want 00 00 1",
               tick_o, pending_o, cfg_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_inc();
    int first;
    first = 0;
    do_reset();
    en_i = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL default_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
      if (tick_o[0] && first == 0) first = k;
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("[TB] FAIL default_first_tick: got cycle %0d, want 2", first);
    end
  endtask

  task automatic test_inc64();
    do_reset();
    drive_write(1'b0, 8'd64);
    checks++;
    if (pending_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL inc64_no_pending: pend=%b, want 00", pending_o);
    end
    en_i = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (tick_o[0] !== ((k % 4) == 0)) begin
        errors++;
        $display("[TB] FAIL inc64_period k=%0d: tick=%b, want %b", k, tick_o[0], (k % 4) == 0);
      end
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL inc64_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
    end
  endtask

  task automatic test_inc96();
    int gaps[3];
    int n;
    int last;
    gaps = '{3, 3, 2};
    n = 0;
    last = 0;
    do_reset();
    drive_write(1'b0, 8'd96);
    en_i = 2'b01;
    for (int k = 1; k <= 24; k++) begin
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL inc96_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
      if (tick_o[0]) begin
        checks++;
        if (k - last != gaps[n % 3]) begin
          errors++;
          $display("[TB] FAIL inc96_gap #%0d: got %0d, want %0d", n, k - last, gaps[n % 3]);
        end
        n++;
        last = k;
      end
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("[TB] FAIL inc96_count: got %0d ticks, want 9", n);
    end
  endtask

  task automatic test_retune();
    int  last;
    int  applied;
    do_reset();
    drive_write(1'b0, 8'd64);
    en_i = 2'b01;
    for (int k = 1; k <= 5; k++) step();
    cfg_ch_i = 1'b0;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL retune_ready_before: ready=%b, want 1", cfg_ready_o);
    end
    drive_write(1'b0, 8'd128);
    checks++;
    if (pending_o[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL retune_pending_rise: pend=%b, want 1", pending_o[0]);
    end
    cfg_ch_i = 1'b0;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retune_ready_ch0: ready=%b, want 0", cfg_ready_o);
    end
    cfg_ch_i = 1'b1;
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL retune_ready_ch1: ready=%b, want 1", cfg_ready_o);
    end
    drive_write(1'b1, 8'd77);
    last = 4;
    applied = 0;
    for (int k = 8; k <= 20; k++) begin
      cfg_ch_i = 1'b0;
      #1;
      checks++;
      if (cfg_ready_o !== m_ready()) begin
        errors++;
        $display("[TB] FAIL retune_ready k=%0d: ready=%b, want %b", k, cfg_ready_o, m_ready());
      end
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL retune_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
      if (tick_o[0]) begin
        checks++;
        if (k - last < 2 || k - last > 4 || (applied > 0 && k - last != 2)) begin
          errors++;
          $display("[TB] FAIL retune_gap k=%0d: got %0d, want 2..4 (2 after apply)", k, k - last);
        end
        applied++;
        last = k;
      end
      checks++;
      if (pending_o[0] !== (applied == 0)) begin
        errors++;
        $display("[TB] FAIL retune_pending k=%0d: pend=%b, want %b", k, pending_o[0], applied == 0);
      end
    end
    checks++;
    if (applied != 7) begin
      errors++;
      $display("[TB] FAIL retune_count: got %0d ticks, want 7", applied);
    end
    en_i = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL retune_ch1_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
    end
  endtask

  task automatic test_hold();
    int wait_cnt;
    do_reset();
    drive_write(1'b1, 8'd64);
    en_i = 2'b10;
    for (int k = 1; k <= 6; k++) step();
    en_i = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick_o[1] !== 1'b0 || tick_o !== m_tick) begin
        errors++;
        $display("[TB] FAIL hold_quiet k=%0d: tick=%b, want 00", k, tick_o);
      end
    end
    en_i = 2'b10;
    wait_cnt = 0;
    for (int k = 1; k <= 8 && wait_cnt == 0; k++) begin
      step();
      if (tick_o[1]) wait_cnt = k;
    end
    checks++;
    if (wait_cnt != 2) begin
      errors++;
      $display("[TB] FAIL hold_resume: first tick after %0d cycles, want 2", wait_cnt);
    end
  endtask

  task automatic test_extremes();
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    do_reset();
    drive_write(1'b0, 8'd0);
    drive_write(1'b1, 8'd255);
    en_i = 2'b11;
    for (int k = 1; k <= 256; k++) begin
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL extremes_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
      if (tick_o[0]) n0++;
      if (tick_o[1]) n1++;
    end
    checks++;
    if (n0 != 0 || n1 != 255) begin
      errors++;
      $display("[TB] FAIL extremes_count: inc0=%0d inc255=%0d, want 0 255", n0, n1);
    end
  endtask

  task automatic test_async_reset();
    int first;
    first = 0;
    do_reset();
    drive_write(1'b0, 8'd64);
    en_i = 2'b01;
    for (int k = 1; k <= 3; k++) step();
    drive_write(1'b0, 8'd200);
    checks++;
    if (tick_o !== 2'b01 || pending_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL areset_setup: tick=%b pend=%b, want 01 01", tick_o, pending_o);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (tick_o !== 2'b00 || pending_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL areset_immediate: tick=%b pend=%b, want 00 00", tick_o, pending_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL areset_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
      if (tick_o[0] && first == 0) first = k;
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("[TB] FAIL areset_default: first tick at %0d, want 2", first);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) en_i = 2'($urandom);
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      cfg_ch_i    = 1'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)      cfg_inc_i = 8'd0;
      else if (r == 1) cfg_inc_i = 8'd255;
      else             cfg_inc_i = 8'($urandom_range(1, 254));
      #1;
      checks++;
      if (cfg_ready_o !== m_ready()) begin
        errors++;
        $display("[TB] FAIL random_ready k=%0d: ready=%b, want %b", k, cfg_ready_o, m_ready());
      end
      step();
      checks++;
      if (tick_o !== m_tick || pending_o !== m_pend) begin
        errors++;
        $display("[TB] FAIL random_model k=%0d: tick=%b pend=%b, want %b %b",
                 k, tick_o, pending_o, m_tick, m_pend);
      end
    end
    cfg_valid_i = 1'b0;
  endtask

`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
  task automatic test_sync();
    do_reset();
    drive_write(1'b0, 8'd128);
    drive_write(1'b1, 8'd32);
    en_i = 2'b10;
    for (int k = 1; k <= 2; k++) step();
    en_i = 2'b11;
    step();
    sync_i      = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 1'b0;
    cfg_inc_i   = 8'd64;
    step();
    sync_i      = 1'b0;
    cfg_valid_i = 1'b0;
    checks++;
    if (tick_o !== 2'b00 || pending_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sync_edge: tick=%b pend=%b, want 00 00", tick_o, pending_o);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (tick_o !== {((k % 8) == 0), ((k % 4) == 0)} || tick_o !== m_tick) begin
        errors++;
        $display("[TB] FAIL sync_align k=%0d: tick=%b, want %b", k, tick_o,
                 {((k % 8) == 0), ((k % 4) == 0)});
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] clk_tick_gen bench start");
    test_reset();
    test_default_inc();
    test_inc64();
    test_inc96();
    test_retune();
    test_hold();
    test_extremes();
    test_async_reset();
    test_random();
`ifdef CLK_TICK_GEN_PHASE_SYNC_EN
    test_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised multi-channel fractional clock-enable generator running in the system clock domain. Each channel holds a phase accumulator and emits a one-cycle tick at an average rate of `f_sys * inc / 2^ACC_W`, so peripheral rates (UART baud, VGA pixel strobe, timers) are derived without extra MMCM/PLL resources. Increments are retuned at runtime through a valid/ready config port. Each update is applied glitch-free at the channel's next tick boundary.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent tick channels (1–16).
- `ACC_W`, 32: accumulator and increment width (8–48).
- `DEFAULT_INC`, `clk_tick_pkg::DEFAULT_INC`: reset increment applied to every channel.

Ports:
- `clk`, in, 1: system clock. This is the block's one clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en_i`, in, `NUM_CH`: per-channel run enable.
- `cfg_valid_i`, in, 1: config write request.
- `cfg_ready_o`, out, 1: config write can be accepted for `cfg_ch_i`.
- `cfg_ch_i`, in, `$clog2(NUM_CH)` (min 1): target channel.
- `cfg_inc_i`, in, `ACC_W`: new increment.
- `tick_o`, out, `NUM_CH`: registered one-cycle tick pulses.
- `pending_o`, out, `NUM_CH`: a channel's update is waiting for its tick boundary.
- `sync_i`, in, 1: phase-align pulse. This port is present only with `CLK_TICK_GEN_PHASE_SYNC_EN`.

## Operation
- Per-channel state: `acc[ACC_W-1:0]`, `inc`, `shadow_inc`, `pending`.
- Enabled channel, each cycle: `{carry, acc} <= acc + inc`, computed ACC_W+1 bits wide with no saturation, wrapping modulo 2^ACC_W. `tick_o[c] <= carry`.
- Disabled channel: `acc` holds and `tick_o[c] <= 0`. On re-enable the channel resumes from the held phase.
- `inc == 0`: the channel never ticks. `inc == 2^ACC_W-1`: the channel ticks on all cycles except one in 2^ACC_W.
- Config handshake:
  - A transfer occurs when `cfg_valid_i && cfg_ready_o`.
  - `cfg_ready_o = !pending[cfg_ch_i]`, which is combinational from `cfg_ch_i`.
  - If `cfg_ch_i >= NUM_CH`, `cfg_ready_o = 1` and the write is dropped.
- Transfer to a disabled channel: `inc <= cfg_inc_i` on the next edge, with no pending state.
- Transfer to an enabled channel: `shadow_inc <= cfg_inc_i` and `pending <= 1`.
  - On the first later edge where that channel's addition produces `carry`, that addition still uses the old `inc`.
  - On the same edge, `inc <= shadow_inc` and `pending <= 0`.
- Disabling a channel while `pending`: the shadow value is applied on the next edge and `pending` clears.
- Per-channel pending state machine: IDLE→PENDING on an accepted write to an enabled channel. PENDING→IDLE on carry, on disable, or on sync.
- Reset values: `acc = 0`, `inc = DEFAULT_INC`, `shadow_inc = 0`, `pending = 0`, `tick_o = 0`, `pending_o = 0`. Reset mid-update discards the pending value.

## Timing
- Latency from addition to tick: the carry produced in cycle N is visible on `tick_o` in cycle N+1.
- First tick after reset with `en_i = 1` from cycle 0: `tick_o` rises at cycle `ceil(2^ACC_W/inc)`.
- The new increment takes effect in the cycle after its boundary tick is registered. The phase is continuous because `acc` is not reset.
- `pending_o` rises the edge after acceptance and falls on the edge that applies the value.
- `sync_i` and a config write in the same cycle: the write is accepted and treated as applied immediately.

## Configuration
- `CLK_TICK_GEN_PHASE_SYNC_EN` defined:
  - `sync_i` exists.
  - A `sync_i` pulse sets every `acc <= 0` and forces `tick_o <= 0` for that edge.
  - Every pending shadow is applied at once and `pending` clears.
  - Result: all channels restart phase-aligned.
- Undefined: `sync_i` and its logic are absent. Channels align only through reset.

## Structure
- Package `clk_tick_pkg` holds:
  - the `ACC_W` default;
  - the function `freq_to_inc(real f_out_mhz, real f_sys_mhz, int acc_w)`, which returns `round(2^acc_w * f_out/f_sys)`;
  - `DEFAULT_INC`, equal to `freq_to_inc(25.175, 50.0, 32)`, derived from the clock-parameter package's system and VGA frequencies;
  - the per-channel state typedef `tick_ch_t` (`acc`, `inc`, `shadow`, `pending`).
- Natural sub-module `clk_tick_ch`: one accumulator channel with its pending logic, instantiated `NUM_CH` times by a generate loop. The top holds the config decode and the ready mux.

## Test plan
All scenarios use `NUM_CH=2`, `ACC_W=8`.
- Write inc 64 to channel 0 while it is disabled, then enable it: `tick_o[0]` pulses every 4 cycles, first at cycle 4 after enable.
- Write inc 96 with the channel disabled, then enable: over 24 cycles exactly 9 ticks, in the repeating gap pattern 3,3,2.
- Channel 0 running at inc 64 (pending state 0), write inc 128 mid-period:
  - `pending_o[0]` is 1 until the next tick;
  - then ticks every 2 cycles;
  - no tick gap shorter than 2 or longer than 4 cycles;
  - `cfg_ready_o` is 0 for ch0 while pending, and writes to ch1 are still accepted.
- `en_i[1]` low for 10 cycles mid-period: no ticks. On re-enable the remaining phase is preserved, so the next tick comes after the leftover cycles, not a full period.
- Assert `rst_n` low asynchronously while `pending_o[0]=1`: all outputs go to 0 immediately. After release, `inc` equals `DEFAULT_INC` and the pending write is lost.
- With `CLK_TICK_GEN_PHASE_SYNC_EN`, channels at inc 64 and inc 32 with skewed phases, pulse `sync_i`: no tick on that edge; afterwards ch0 ticks at +4 and ch1 at +8, coincident every 8 cycles.
